// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the data port. The data port has fixed priority, limited by
// a starvation counter so that a waiting fetch is eventually served.
// Completion pulses and read data are registered. The stall outputs are
// combinational so the hazard logic can freeze the pipeline in the same
// cycle as the request.

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_next;

    logic              i_elig;
    logic              d_elig;
    logic              d_misaligned;
    logic              grant_i;
    logic              grant_d;

    logic              i_done_next;
    logic [DATA_W-1:0] i_rdata_next;
    logic              d_done_next;
    logic [DATA_W-1:0] d_rdata_next;
    logic              d_err_next;
    logic              mem_req_next;
    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;

    // A port that is completing this cycle is masked so its still-high
    // request is not granted a second time.
    assign i_elig       = i_req & ~i_done;
    assign d_elig       = d_req & ~d_done;
    assign d_misaligned = (d_addr[1:0] != 2'b00);

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    // Arbitration in IDLE: data wins unless the fetch has waited too long.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (d_elig && (!i_elig || (starve_cnt < LIMIT))) begin
                grant_d = 1'b1;
            end else if (i_elig) begin
                grant_i = 1'b1;
            end
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Next state and starvation count; a misaligned data grant completes
    // immediately and never leaves IDLE.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next      = BUSY_I;
                    starve_cnt_next = '0;
                end else if (grant_d) begin
                    if (!d_misaligned) begin
                        state_next = BUSY_D;
                    end
                    if (i_elig) begin
                        if (starve_cnt != LIMIT) begin
                            starve_cnt_next = starve_cnt + CNT_W'(1);
                        end
                    end else if (!i_req) begin
                        starve_cnt_next = '0;
                    end
                end else if (!i_req) begin
                    starve_cnt_next = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; the memory command holds its
    // value until the access is acknowledged.
    always_comb begin
        i_done_next    = 1'b0;
        i_rdata_next   = '0;
        d_done_next    = 1'b0;
        d_rdata_next   = '0;
        d_err_next     = 1'b0;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = i_addr;
                    mem_wdata_next = '0;
                end else if (grant_d) begin
                    if (d_misaligned) begin
                        d_done_next = 1'b1;
                        d_err_next  = 1'b1;
                    end else begin
                        mem_req_next   = 1'b1;
                        mem_we_next    = d_we;
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                    end
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    i_done_next  = 1'b1;
                    i_rdata_next = mem_rdata;
                    mem_req_next = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    d_done_next  = 1'b1;
                    d_rdata_next = mem_we ? '0 : mem_rdata;
                    mem_req_next = 1'b0;
                end
            end
            default: begin
                mem_req_next = 1'b0;
            end
        endcase
    end

    // Registered outputs, cleared by reset so an abandoned access leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_done    <= i_done_next;
            i_rdata   <= i_rdata_next;
            d_done    <= d_done_next;
            d_rdata   <= d_rdata_next;
            d_err     <= d_err_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by a randomized phase.
// A transaction-level reference model predicts every output each cycle, and
// a small memory responder with variable latency serves the arbiter.

module tb_mem_port_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory contents seen by the responder, and the model's own copy.
    logic [31:0] mem_array [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    // Memory responder state.
    logic        resp_active = 1'b0;
    int          resp_cnt    = 0;
    logic [31:0] resp_addr;
    logic        resp_we;
    logic [31:0] resp_wdata;
    int          mem_lat     = 1;
    logic        rand_lat    = 1'b0;
    logic        random_mode = 1'b0;

    // Observation helpers.
    logic        saw_i_done   = 1'b0;
    logic        saw_d_done   = 1'b0;
    logic        prev_mem_req = 1'b0;
    int          grant_log[$];
    int          i_done_cnt   = 0;

    // Reference model: one in-flight transaction plus predicted outputs.
    logic        model_valid = 1'b0;
    logic        m_busy;
    logic        m_port_d;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_cnt;
    logic        e_i_done;
    logic [31:0] e_i_rdata;
    logic        e_d_done;
    logic [31:0] e_d_rdata;
    logic        e_d_err;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;

    function automatic logic [31:0] defWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return defWord(a);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        cmp("i_done", {31'd0, i_done}, {31'd0, e_i_done});
        cmp("i_rdata", i_rdata, e_i_rdata);
        cmp("i_stall", {31'd0, i_stall}, {31'd0, i_req & ~e_i_done});
        cmp("d_done", {31'd0, d_done}, {31'd0, e_d_done});
        cmp("d_rdata", d_rdata, e_d_rdata);
        cmp("d_err", {31'd0, d_err}, {31'd0, e_d_err});
        cmp("d_stall", {31'd0, d_stall}, {31'd0, d_req & ~e_d_done});
        cmp("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
        if (e_mem_req) begin
            cmp("mem_we", {31'd0, mem_we}, {31'd0, e_mem_we});
            cmp("mem_addr", mem_addr, e_mem_addr);
            cmp("mem_wdata", mem_wdata, e_mem_wdata);
        end
        cmp("one_done_only", {31'd0, i_done & d_done}, 32'd0);
    endtask

    task automatic modelStep();
        logic        ie;
        logic        de;
        logic        take_d;
        logic        take_i;
        logic        n_i_done;
        logic        n_d_done;
        logic        n_d_err;
        logic [31:0] n_i_rdata;
        logic [31:0] n_d_rdata;
        if (rst) begin
            model_valid = 1'b1;
            m_busy      = 1'b0;
            m_port_d    = 1'b0;
            m_we        = 1'b0;
            m_addr      = '0;
            m_wdata     = '0;
            m_cnt       = 0;
            e_i_done    = 1'b0;
            e_i_rdata   = '0;
            e_d_done    = 1'b0;
            e_d_rdata   = '0;
            e_d_err     = 1'b0;
            e_mem_req   = 1'b0;
            e_mem_we    = 1'b0;
            e_mem_addr  = '0;
            e_mem_wdata = '0;
            return;
        end
        if (!model_valid) return;
        n_i_done  = 1'b0;
        n_d_done  = 1'b0;
        n_d_err   = 1'b0;
        n_i_rdata = '0;
        n_d_rdata = '0;
        if (m_busy) begin
            if (mem_ack) begin
                if (m_port_d) begin
                    n_d_done = 1'b1;
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else n_d_rdata = refRead(m_addr);
                end else begin
                    n_i_done  = 1'b1;
                    n_i_rdata = refRead(m_addr);
                end
                m_busy    = 1'b0;
                e_mem_req = 1'b0;
            end
        end else begin
            ie     = i_req && !e_i_done;
            de     = d_req && !e_d_done;
            take_d = de && (!ie || m_cnt < LIMIT);
            take_i = ie && !take_d;
            if (take_i) m_cnt = 0;
            else if (take_d && ie) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
            else if (!i_req) m_cnt = 0;
            if (take_i) begin
                m_busy      = 1'b1;
                m_port_d    = 1'b0;
                m_we        = 1'b0;
                m_addr      = i_addr;
                m_wdata     = '0;
                e_mem_req   = 1'b1;
                e_mem_we    = 1'b0;
                e_mem_addr  = i_addr;
                e_mem_wdata = '0;
            end else if (take_d) begin
                if ((d_addr % 4) != 0) begin
                    n_d_done = 1'b1;
                    n_d_err  = 1'b1;
                end else begin
                    m_busy      = 1'b1;
                    m_port_d    = 1'b1;
                    m_we        = d_we;
                    m_addr      = d_addr;
                    m_wdata     = d_wdata;
                    e_mem_req   = 1'b1;
                    e_mem_we    = d_we;
                    e_mem_addr  = d_addr;
                    e_mem_wdata = d_wdata;
                end
            end
        end
        e_i_done  = n_i_done;
        e_i_rdata = n_i_rdata;
        e_d_done  = n_d_done;
        e_d_rdata = n_d_rdata;
        e_d_err   = n_d_err;
    endtask

    function automatic logic [31:0] pickIAddr();
        logic [31:0] a;
        a = 32'h0040_0000 + ($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
        return a;
    endfunction

    function automatic logic [31:0] pickDAddr();
        logic [31:0] a;
        a = 32'h1000_8000 + ($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
        return a;
    endfunction

    task automatic newDReq();
        d_req   = 1'b1;
        d_we    = ($urandom_range(0, 1) == 1);
        d_addr  = pickDAddr();
        d_wdata = $urandom;
    endtask

    task automatic applyStimulus();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!resp_active && mem_req === 1'b1) begin
            resp_active = 1'b1;
            resp_cnt    = rand_lat ? $urandom_range(1, 4) : mem_lat;
            resp_addr   = mem_addr;
            resp_we     = mem_we;
            resp_wdata  = mem_wdata;
        end
        if (resp_active) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_ack     = 1'b1;
                resp_active = 1'b0;
                if (resp_we) mem_array[resp_addr] = resp_wdata;
                else mem_rdata = mem_array.exists(resp_addr) ? mem_array[resp_addr] : defWord(resp_addr);
            end
        end
        if (random_mode) begin
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req  = 1'b1;
                    i_addr = pickIAddr();
                end
            end else if (saw_i_done) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = pickIAddr();
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) newDReq();
            end else if (saw_d_done) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else newDReq();
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (model_valid) checkOutput();
            if (mem_req === 1'b1 && prev_mem_req !== 1'b1) grant_log.push_back(mem_addr[28] ? 1 : 0);
            prev_mem_req = mem_req;
            if (i_done === 1'b1) i_done_cnt++;
            saw_i_done = (i_done === 1'b1);
            saw_d_done = (d_done === 1'b1);
            modelStep();
            @(posedge clk);
            #1;
            applyStimulus();
        end
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        int g_before;
        int c_before;
        int max_run;
        int run;
        bit drained;

        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_array[32'h0040_0000] = 32'h2008_0005;
        ref_mem[32'h0040_0000]   = 32'h2008_0005;

        tick(2);
        cmp("rst_mem_req", {31'd0, mem_req}, 32'd0);
        cmp("rst_mem_addr", mem_addr, 32'd0);
        cmp("rst_mem_we", {31'd0, mem_we}, 32'd0);
        cmp("rst_mem_wdata", mem_wdata, 32'd0);
        cmp("rst_i_done", {31'd0, i_done}, 32'd0);
        cmp("rst_d_rdata", d_rdata, 32'd0);

        $display("[TB] single fetch and done mask");
        rst = 1'b0;
        g_before = grant_log.size();
        c_before = i_done_cnt;
        i_req  = 1'b1;
        i_addr = 32'h0040_0000;
        mem_lat = 1;
        tick(1);
        cmp("t1_mem_req", {31'd0, mem_req}, 32'd1);
        cmp("t1_mem_addr", mem_addr, 32'h0040_0000);
        cmp("t1_mem_we", {31'd0, mem_we}, 32'd0);
        cmp("t1_i_stall", {31'd0, i_stall}, 32'd1);
        tick(1);
        cmp("t1_i_done", {31'd0, i_done}, 32'd1);
        cmp("t1_i_rdata", i_rdata, 32'h2008_0005);
        cmp("t1_i_stall_done", {31'd0, i_stall}, 32'd0);
        tick(1);
        cmp("t1_i_rdata_clear", i_rdata, 32'd0);
        cmp("t1_mem_req_low", {31'd0, mem_req}, 32'd0);
        i_req = 1'b0;
        tick(4);
        cmp("t6_fetch_accesses", grant_log.size() - g_before, 32'd1);
        cmp("t6_i_done_pulses", i_done_cnt - c_before, 32'd1);

        $display("[TB] store then load");
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1000_8004;
        d_wdata = 32'hDEAD_BEEF;
        mem_lat = 3;
        tick(1);
        cmp("t2_mem_we", {31'd0, mem_we}, 32'd1);
        cmp("t2_mem_addr", mem_addr, 32'h1000_8004);
        cmp("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(2);
        cmp("t2_mem_req_held", {31'd0, mem_req}, 32'd1);
        cmp("t2_mem_wdata_held", mem_wdata, 32'hDEAD_BEEF);
        tick(1);
        cmp("t2_d_done", {31'd0, d_done}, 32'd1);
        cmp("t2_store_rdata", d_rdata, 32'd0);
        tick(1);
        d_req = 1'b0;
        tick(1);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_wdata = '0;
        mem_lat = 2;
        tick(3);
        cmp("t2_load_done", {31'd0, d_done}, 32'd1);
        cmp("t2_load_rdata", d_rdata, 32'hDEAD_BEEF);
        tick(1);
        d_req = 1'b0;
        tick(2);

        $display("[TB] simultaneous requests");
        grant_log.delete();
        mem_lat = 1;
        i_req  = 1'b1;
        i_addr = 32'h0040_0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1000_8008;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (saw_d_done) d_addr = d_addr + 4;
            if (saw_i_done) i_addr = i_addr + 4;
        end
        drained = 1'b0;
        for (int k = 0; k < 20 && !drained; k++) begin
            tick(1);
            if (saw_i_done) i_req = 1'b0;
            if (saw_d_done) d_req = 1'b0;
            drained = !i_req && !d_req;
        end
        cmp("t3_drained", {31'd0, drained}, 32'd1);
        tick(2);
        cmp("t3_first_grant_data", grant_log.size() > 0 ? grant_log[0] : -1, 32'd1);
        cmp("t3_second_grant_fetch", grant_log.size() > 1 ? grant_log[1] : -1, 32'd0);
        max_run = 0;
        run = 0;
        foreach (grant_log[k]) begin
            run = (grant_log[k] == 1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        cmp("t3_data_run_within_limit", {31'd0, max_run <= LIMIT}, 32'd1);

        $display("[TB] misaligned store with pending fetch");
        grant_log.delete();
        i_req   = 1'b1;
        i_addr  = 32'h0040_0020;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1000_8002;
        d_wdata = 32'h1234_5678;
        mem_lat = 1;
        tick(1);
        cmp("t4_d_done", {31'd0, d_done}, 32'd1);
        cmp("t4_d_err", {31'd0, d_err}, 32'd1);
        cmp("t4_d_rdata", d_rdata, 32'd0);
        cmp("t4_no_mem_req", {31'd0, mem_req}, 32'd0);
        tick(1);
        d_req = 1'b0;
        cmp("t4_fetch_req", {31'd0, mem_req}, 32'd1);
        cmp("t4_fetch_addr", mem_addr, 32'h0040_0020);
        cmp("t4_d_err_clear", {31'd0, d_err}, 32'd0);
        tick(1);
        cmp("t4_i_done", {31'd0, i_done}, 32'd1);
        tick(1);
        i_req = 1'b0;
        tick(2);
        cmp("t4_only_fetch_granted", grant_log.size(), 32'd1);

        $display("[TB] reset mid-access");
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h1000_8004;
        mem_lat = 4;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        d_req = 1'b0;
        cmp("t5_mem_req", {31'd0, mem_req}, 32'd0);
        cmp("t5_mem_addr", mem_addr, 32'd0);
        cmp("t5_mem_we", {31'd0, mem_we}, 32'd0);
        cmp("t5_d_done", {31'd0, d_done}, 32'd0);
        tick(2);
        cmp("t5_stale_ack_ignored", {30'd0, d_done, i_done}, 32'd0);
        cmp("t5_stale_no_req", {31'd0, mem_req}, 32'd0);
        tick(1);
        i_req   = 1'b1;
        i_addr  = 32'h0040_0000;
        mem_lat = 2;
        tick(3);
        cmp("t5_fetch_done", {31'd0, i_done}, 32'd1);
        cmp("t5_fetch_rdata", i_rdata, 32'h2008_0005);
        tick(1);
        i_req = 1'b0;
        tick(2);

        $display("[TB] randomized traffic");
        rand_lat    = 1'b1;
        random_mode = 1'b1;
        tick(2500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
